// File: rtl/alk_pkg.sv
// Shared types and constants for the ALK multiply/divide step sequencer.
// Pure definitions: no latency, no flow control.
// Not applicable: no backpressure.
package alk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DFIX,
        ST_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    localparam int unsigned STEPS_BYTE = 8;
    localparam int unsigned STEPS_WORD = 16;
    localparam int unsigned STEPS_LONG = 32;

    localparam int CNT_W = $clog2(STEPS_LONG) + 1;

    // Reserved size code 11 falls through to the long iteration count.
    function automatic int unsigned size_steps(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_steps = STEPS_BYTE;
            SZ_WORD: size_steps = STEPS_WORD;
            SZ_LONG: size_steps = STEPS_LONG;
            default: size_steps = STEPS_LONG;
        endcase
    endfunction

endpackage

// File: rtl/alkmdcnt.sv
// Loadable down-counter for the mul/div step count, flags the final step.
// Latency: load/decrement visible the cycle after the edge; is_last is combinational.
// No backpressure: decrement saturates at zero, clear overrides load.
module alkmdcnt
    import alk_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         is_last
);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_last = (cnt == '0);

endmodule

// File: rtl/alkmdseq.sv
// DC615 ALK multiply/divide step sequencer: N ALU iterations plus divide restore step.
// Latency: MUL N cycles then done; DIV N+1 cycles then done (from the start edge).
// Holds the microsequencer via stall_l while busy; abort returns to IDLE with no done.
module alkmdseq
    import alk_pkg::*;
#(
    parameter int MAXSTEPS = 32
) (
    input  logic                     qdclk_l,
    input  logic                     reset_l,
    input  logic                     mul_start_h,
    input  logic                     div_start_h,
    input  logic [1:0]               size_h,
    input  logic                     mq_lsb_h,
    input  logic                     alkc_flag_h,
    input  logic                     abort_h,
    output logic                     busy_h,
    output logic                     stall_l,
    output logic                     done_h,
    output logic                     alpctl_mul_l,
    output logic                     alu_add_h,
    output logic                     alu_sub_h,
    output logic                     shift_en_h,
    output logic                     quo_bit_h,
    output logic [$clog2(MAXSTEPS):0] step_cnt_h
);

    localparam int CW = $clog2(MAXSTEPS) + 1;

    state_t        state_q, state_d;
    logic          first_q, first_d;
    logic          cnt_clr, cnt_load, cnt_dec;
    logic          cnt_last;
    logic [CW-1:0] cnt_load_val;

    assign cnt_load_val = CW'(size_steps(size_h) - 1);

    alkmdcnt #(
        .W (CW)
    ) u_cnt (
        .core_clk (qdclk_l),
        .arst_n   (reset_l),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (step_cnt_h),
        .is_last  (cnt_last)
    );

    always_ff @(posedge qdclk_l or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        first_d      = 1'b0;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        busy_h       = 1'b0;
        stall_l      = 1'b1;
        done_h       = 1'b0;
        alpctl_mul_l = 1'b1;
        alu_add_h    = 1'b0;
        alu_sub_h    = 1'b0;
        shift_en_h   = 1'b0;
        quo_bit_h    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Multiply wins when both requests arrive together.
                if (mul_start_h) begin
                    state_d  = ST_MUL;
                    cnt_load = 1'b1;
                end else if (div_start_h) begin
                    state_d  = ST_DIV;
                    cnt_load = 1'b1;
                    first_d  = 1'b1;
                end
            end
            ST_MUL: begin
                busy_h       = 1'b1;
                stall_l      = 1'b0;
                alpctl_mul_l = 1'b0;
                shift_en_h   = 1'b1;
                alu_add_h    = mq_lsb_h;
                if (abort_h) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DIV: begin
                busy_h       = 1'b1;
                stall_l      = 1'b0;
                alpctl_mul_l = 1'b0;
                shift_en_h   = 1'b1;
                // Non-restoring: the first trial always subtracts, later ones follow the carry.
                alu_sub_h    = first_q | alkc_flag_h;
                alu_add_h    = ~first_q & ~alkc_flag_h;
                quo_bit_h    = ~first_q & alkc_flag_h;
                if (abort_h) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_last) begin
                    state_d = ST_DFIX;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DFIX: begin
                busy_h    = 1'b1;
                stall_l   = 1'b0;
                quo_bit_h = alkc_flag_h;
                alu_add_h = ~alkc_flag_h;
                if (abort_h) begin
                    cnt_clr = 1'b1;
                end
                state_d = abort_h ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                done_h  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_alkmdseq.sv
// Randomized self-checking bench for alkmdseq against a per-step behavioural model.
module tb_alkmdseq;

    logic       qdclk_l = 1'b0;
    logic       reset_l;
    logic       mul_start_h, div_start_h;
    logic [1:0] size_h;
    logic       mq_lsb_h, alkc_flag_h, abort_h;
    logic       busy_h, stall_l, done_h, alpctl_mul_l;
    logic       alu_add_h, alu_sub_h, shift_en_h, quo_bit_h;
    logic [5:0] step_cnt_h;

    int total = 0;
    int bad   = 0;

    always #5 qdclk_l = ~qdclk_l;

    alkmdseq #(.MAXSTEPS(32)) dut (
        .qdclk_l      (qdclk_l),
        .reset_l      (reset_l),
        .mul_start_h  (mul_start_h),
        .div_start_h  (div_start_h),
        .size_h       (size_h),
        .mq_lsb_h     (mq_lsb_h),
        .alkc_flag_h  (alkc_flag_h),
        .abort_h      (abort_h),
        .busy_h       (busy_h),
        .stall_l      (stall_l),
        .done_h       (done_h),
        .alpctl_mul_l (alpctl_mul_l),
        .alu_add_h    (alu_add_h),
        .alu_sub_h    (alu_sub_h),
        .shift_en_h   (shift_en_h),
        .quo_bit_h    (quo_bit_h),
        .step_cnt_h   (step_cnt_h)
    );

    // Observed outputs packed as {busy, stall_l, done, alpctl_mul_l, add, sub, shift, quo, step_cnt}.
    logic [13:0] obs;
    assign obs = {busy_h, stall_l, done_h, alpctl_mul_l, alu_add_h, alu_sub_h,
                  shift_en_h, quo_bit_h, step_cnt_h};

    function automatic logic [13:0] mk(input bit busy, input bit stl, input bit done,
                                       input bit alp, input bit add, input bit sub,
                                       input bit shf, input bit quo, input int cnt);
        return {busy, stl, done, alp, add, sub, shf, quo, 6'(cnt)};
    endfunction

    function automatic logic [13:0] rst_val();
        return mk(0, 1, 0, 1, 0, 0, 0, 0, 0);
    endfunction

    // One complete operation with cycle-by-cycle checking.
    // flags[k] is the carry flag presented during step k; flags[n+1] during the restore step.
    task automatic run_op(input bit is_div, input logic [1:0] size, input bit both,
                          input bit noise, input logic [31:0] lsbs, input logic [33:0] flags,
                          input int abort_at, input string tag);
        int          n;
        bit          dv;
        bit          f;
        bit          first;
        logic [13:0] exp;
        n  = (size == 2'b00) ? 8 : (size == 2'b01) ? 16 : 32;
        dv = is_div && !both;

        @(negedge qdclk_l);
        mul_start_h = both | ~is_div;
        div_start_h = both | is_div;
        size_h      = size;
        abort_h     = 1'b0;
        #1;
        total++;
        if (obs !== rst_val()) begin
            bad++;
            $display("FAIL %s idle: got %h want %h", tag, obs, rst_val());
        end

        for (int k = 1; k <= n + (dv ? 1 : 0); k++) begin
            @(negedge qdclk_l);
            mul_start_h = noise ? 1'($urandom) : 1'b0;
            div_start_h = noise ? 1'($urandom) : 1'b0;
            if (noise) size_h = 2'($urandom);
            mq_lsb_h    = lsbs[k-1];
            alkc_flag_h = flags[k];
            abort_h     = (k == abort_at);
            #1;
            f     = flags[k];
            first = (k == 1);
            if (k > n)
                exp = mk(1, 0, 0, 1, !f, 0, 0, f, 0);
            else if (dv)
                exp = mk(1, 0, 0, 0, !first && !f, first || f, 1, !first && f, n - k);
            else
                exp = mk(1, 0, 0, 0, lsbs[k-1], 0, 1, 0, n - k);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s step %0d: got %h want %h", tag, k, obs, exp);
            end
            if (k == abort_at) begin
                for (int j = 0; j < 2; j++) begin
                    @(negedge qdclk_l);
                    abort_h = 1'b0; mul_start_h = 1'b0; div_start_h = 1'b0;
                    #1;
                    total++;
                    if (obs !== rst_val()) begin
                        bad++;
                        $display("FAIL %s post-abort %0d: got %h want %h", tag, j, obs, rst_val());
                    end
                end
                return;
            end
        end

        // Completion cycle; a start or abort here must have no effect.
        @(negedge qdclk_l);
        mul_start_h = noise;
        div_start_h = 1'b0;
        abort_h     = noise ? 1'($urandom) : 1'b0;
        #1;
        total++;
        if (obs !== mk(0, 1, 1, 1, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL %s done: got %h want %h", tag, obs, mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        end
        @(negedge qdclk_l);
        mul_start_h = 1'b0; abort_h = 1'b0;
        #1;
        total++;
        if (obs !== rst_val()) begin
            bad++;
            $display("FAIL %s after done: got %h want %h", tag, obs, rst_val());
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        #1;
        total++;
        if (obs !== rst_val()) begin
            bad++;
            $display("FAIL reset_initial: got %h want %h", obs, rst_val());
        end
        repeat (2) @(negedge qdclk_l);
        reset_l = 1'b1;
        // Start a byte multiply and pull reset during its third step.
        @(negedge qdclk_l);
        mul_start_h = 1'b1; size_h = 2'b00;
        repeat (3) begin
            @(negedge qdclk_l);
            mul_start_h = 1'b0; mq_lsb_h = 1'b1;
        end
        #1;
        total++;
        if (busy_h !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_busy: got %b want 1", busy_h);
        end
        #2 reset_l = 1'b0;
        #1;
        total++;
        if (obs !== rst_val()) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", obs, rst_val());
        end
        @(negedge qdclk_l);
        reset_l = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge qdclk_l);
            #1;
            total++;
            if (obs !== rst_val()) begin
                bad++;
                $display("FAIL reset_release %0d: got %h want %h", j, obs, rst_val());
            end
        end
    endtask

    task automatic test_mul_byte();
        run_op(0, 2'b00, 0, 0, 32'h0000_00A5, 34'($urandom), 0, "mul_byte");
    endtask

    task automatic test_div_long_carry();
        run_op(1, 2'b10, 0, 0, 32'($urandom), '1, 0, "div_long");
    endtask

    task automatic test_div_word_restore();
        run_op(1, 2'b01, 0, 0, 32'($urandom), 34'h0_0000_003E, 0, "div_word");
    endtask

    task automatic test_abort();
        run_op(1, 2'b01, 0, 0, 32'($urandom), {2'b0, 32'($urandom)}, 10, "abort_div");
        run_op(0, 2'b00, 0, 0, 32'($urandom), 34'($urandom), 3, "abort_mul");
        run_op(1, 2'b00, 0, 0, 32'($urandom), 34'($urandom), 9, "abort_dfix");
    endtask

    task automatic test_illegal();
        run_op(1, 2'b00, 1, 0, 32'h0000_0F0F, 34'($urandom), 0, "both_starts");
        run_op(0, 2'b01, 0, 1, 32'($urandom), 34'($urandom), 0, "start_busy");
        run_op(1, 2'b10, 0, 1, 32'($urandom), {2'b0, 32'($urandom)}, 0, "div_busy");
        run_op(0, 2'b11, 0, 0, 32'($urandom), 34'($urandom), 0, "size11");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit          dv;
            logic [1:0]  sz;
            int          n;
            int          ab;
            dv = 1'($urandom);
            sz = 2'($urandom);
            n  = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n + (dv ? 1 : 0))) : 0;
            run_op(dv, sz, 1'($urandom_range(0, 5) == 0), 1'($urandom), 32'($urandom),
                   {2'($urandom), 32'($urandom)}, ab, "random");
        end
    endtask

    initial begin
        mul_start_h = 1'b0; div_start_h = 1'b0; size_h = 2'b00;
        mq_lsb_h = 1'b0; alkc_flag_h = 1'b0; abort_h = 1'b0;
        test_reset();
        test_mul_byte();
        test_div_long_carry();
        test_div_word_restore();
        test_abort();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
